csr_wb_master: RTL

- CSR-bus peripheral that lets software issue single Wishbone master cycles onto the conbus.
- This is the reverse of the WB→CSR bridge: CPU code programs address, data and control registers over CSR, and the block runs one classic Wishbone read or write.
- Intended as a conbus master on a spare master port. Used for bus probing, peripheral bring-up and copy loops with address auto-increment.

---
 rtl/csr_wb_master.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/csr_wb_master.sv
// CSR-programmed single-cycle classic Wishbone master.
// Software loads ADDR/WDATA/CTRL and the block runs one read or write, with optional timeout and address auto-increment.
module csr_wb_master #(
  parameter logic [3:0]  csr_addr        = 4'h0,
  parameter logic [15:0] DEFAULT_TIMEOUT = 16'd1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  input  logic        wb_ack_i,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    BUS  = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] addr_r, wdata_r, rdata_r, csr_do_r, rd_mux_s;
  logic [15:0] tmo_r, cnt_r, cnt_inc_s;
  logic [3:0]  sel_r;
  logic        we_r, inc_r, irq_en_r, done_r, timeout_r, cyc_r, irq_r;
  logic        csr_sel_s, csr_wr_s, busy_s, start_s, ack_s, tmo_hit_s;
  logic        status_wr_s;
  logic [2:0]  idx_s;
  logic        unused_s;

  assign csr_sel_s   = (csr_a[13:10] == csr_addr);
  assign csr_wr_s    = csr_sel_s & csr_we;
  assign idx_s       = csr_a[2:0];
  assign busy_s      = (state_r != IDLE);
  assign start_s     = csr_wr_s & (idx_s == 3'd3) & csr_di[0] & ~busy_s;
  assign status_wr_s = csr_wr_s & (idx_s == 3'd4);
  assign cnt_inc_s   = cnt_r + 16'd1;
  assign ack_s       = (state_r == BUS) & wb_ack_i;
  // The ack wins on the last allowed cycle, so the timeout only fires with ack low.
  assign tmo_hit_s   = (state_r == BUS) & ~wb_ack_i & (tmo_r != 16'd0) & (cnt_inc_s == tmo_r);
  assign unused_s    = ^csr_a[9:3];

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = ARM;
        else         state_nxt_s = IDLE;
      end
      ARM: state_nxt_s = BUS;
      BUS: begin
        if (ack_s || tmo_hit_s) state_nxt_s = IDLE;
        else                    state_nxt_s = BUS;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // CSR readback multiplexer.
  always_comb begin
    rd_mux_s = 32'd0;
    case (idx_s)
      3'd0:    rd_mux_s = addr_r;
      3'd1:    rd_mux_s = wdata_r;
      3'd2:    rd_mux_s = rdata_r;
      3'd3:    rd_mux_s = {24'd0, sel_r, irq_en_r, inc_r, we_r, 1'b0};
      3'd4:    rd_mux_s = {29'd0, timeout_r, done_r, busy_s};
      3'd5:    rd_mux_s = {16'd0, tmo_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Register file, sequencer state and Wishbone output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r   <= IDLE;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      rdata_r   <= 32'd0;
      csr_do_r  <= 32'd0;
      tmo_r     <= DEFAULT_TIMEOUT;
      cnt_r     <= 16'd0;
      sel_r     <= 4'hf;
      we_r      <= 1'b0;
      inc_r     <= 1'b0;
      irq_en_r  <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      cyc_r     <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cyc_r    <= (state_nxt_s == BUS);
      cnt_r    <= (state_r == BUS) ? cnt_inc_s : 16'd0;
      csr_do_r <= csr_sel_s ? rd_mux_s : 32'd0;
      irq_r    <= irq_en_r & (done_r | timeout_r);

      if (csr_wr_s && !busy_s) begin
        case (idx_s)
          3'd0: addr_r  <= {csr_di[31:2], 2'b00};
          3'd1: wdata_r <= csr_di;
          3'd3: begin
            we_r     <= csr_di[1];
            inc_r    <= csr_di[2];
            irq_en_r <= csr_di[3];
            sel_r    <= csr_di[7:4];
          end
          3'd5:    tmo_r <= csr_di[15:0];
          default: ;
        endcase
      end

      // Bus-side updates only happen while busy, when CSR writes above are blocked.
      if (ack_s && inc_r) addr_r <= addr_r + 32'd4;
      if (ack_s && !we_r) rdata_r <= wb_dat_i;

      if (ack_s)                          done_r <= 1'b1;
      else if (start_s)                   done_r <= 1'b0;
      else if (status_wr_s && csr_di[1])  done_r <= 1'b0;

      if (tmo_hit_s)                      timeout_r <= 1'b1;
      else if (start_s)                   timeout_r <= 1'b0;
      else if (status_wr_s && csr_di[2])  timeout_r <= 1'b0;
    end
  end

  assign csr_do   = csr_do_r;
  assign wb_adr_o = addr_r;
  assign wb_dat_o = wdata_r;
  assign wb_sel_o = sel_r;
  assign wb_we_o  = we_r;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;
  assign wb_cti_o = 3'b000;
  assign irq      = irq_r;

endmodule
